mem_req_arbiter: RTL and testbench

- Shares one single-port block RAM between NUM_REQ simple request/grant masters (e.g. an AXI slave read path, a write path, a debug/backdoor loader).
- Round-robin arbitration with a per-master hold limit; one RAM access per cycle.
- Expands byte strobes to the RAM's bit-write mask and routes read data back with a 1-cycle read latency.
- Sits directly in front of the bit-write block RAM model.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_rr_pick.sv | 42 ++++
 rtl/mem_req_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the block-RAM request arbiter.
// No logic of its own; pure declarations and constant functions.
// Not applicable: no handshake lives here.
package mem_arb_pkg;

    // Widest supported configuration: up to 8 requesters, up to 256-bit data.
    localparam int MAX_REQ = 8;
    localparam int MAX_DW  = 256;

    // Requester index wide enough for MAX_REQ masters.
    localparam int REQ_IDX_W = $clog2(MAX_REQ);
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Index width actually needed for a given requester count.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Byte-strobe to bit-mask expansion: bit b of the mask follows strobe b/8.
    function automatic logic strb_mask_bit(input logic [MAX_DW/8-1:0] strb, input int b);
        return strb[b/8];
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin picker: first eligible requester at or after rr_ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; excluded or idle masters simply are not selected.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  req_idx_t           rr_ptr_i,
    input  logic [NUM_REQ-1:0] excl_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output req_idx_t           idx_o,
    output logic               vld_o
);

    logic [NUM_REQ-1:0] elig;

    // Scan offsets 0..NUM_REQ-1 from rr_ptr_i; the first eligible slot wins.
    always_comb begin
        int c;
        elig  = req_i & ~excl_i;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(rr_ptr_i) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!vld_o && elig[k] && (k == c)) begin
                    vld_o    = 1'b1;
                    idx_o    = req_idx_t'(k);
                    gnt_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one single-port bit-write block RAM between NUM_REQ request/grant masters.
// Latency: grant and RAM drive same cycle as request; read data returns one cycle later.
// Backpressure: req_i held until gnt_o; read return has no ready and must be accepted.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] wstrb_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [NUM_REQ-1:0]             rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           ram_cs_o,
    output logic                           ram_we_o,
    output logic [ADDR_WIDTH-1:0]          ram_addr_o,
    output logic [DATA_WIDTH-1:0]          ram_wstrb_o,
    output logic [DATA_WIDTH-1:0]          ram_din_o,
    input  logic [DATA_WIDTH-1:0]          ram_dout_i
);

    localparam int SW = DATA_WIDTH / 8;

    req_idx_t   rr_ptr_q, rr_ptr_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    req_idx_t   last_owner_q, last_owner_d;
    logic       rd_pend_q, rd_pend_d;
    req_idx_t   rd_idx_q, rd_idx_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] excl;
    logic [NUM_REQ-1:0] pick_gnt;
    req_idx_t           pick_idx;
    logic               pick_vld;
    logic               keep;
    logic               others_req;
    logic               win_vld;
    req_idx_t           win_idx;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [SW-1:0]         sel_strb;
    logic [MAX_DW/8-1:0]   strb_ext;

    // Locality and fairness: keep the previous winner while under its hold
    // limit; once at the limit, step it aside if anyone else is waiting.
    // A non-zero hold_cnt_q means last_owner_q was granted in the previous cycle.
    always_comb begin
        owner_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            owner_oh[k] = (last_owner_q == req_idx_t'(k));
        end
        others_req = |(req_i & ~owner_oh);
        keep       = (|(req_i & owner_oh)) && (hold_cnt_q != 4'd0)
                     && (hold_cnt_q < 4'(MAX_HOLD));
        excl       = ((hold_cnt_q == 4'(MAX_HOLD)) && others_req) ? owner_oh : '0;
    end

    mem_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .excl_i   (excl),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .vld_o    (pick_vld)
    );

    // Final winner: held owner overrides the round-robin pick.
    always_comb begin
        win_vld = keep | pick_vld;
        win_idx = keep ? last_owner_q : pick_idx;
        gnt_o   = keep ? owner_oh : pick_gnt;
    end

    // Request mux; with no winner win_idx is 0, so master 0 drives the idle RAM bus.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == req_idx_t'(k)) begin
                sel_we    = we_i[k];
                sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = wstrb_i[k*SW +: SW];
            end
        end
    end

    // RAM drive: byte strobes widen to a bit mask; reads never write any bit.
    always_comb begin
        strb_ext         = '0;
        strb_ext[SW-1:0] = sel_strb;
        ram_cs_o         = win_vld;
        ram_we_o         = win_vld & sel_we;
        ram_addr_o       = sel_addr;
        ram_din_o        = sel_wdata;
        ram_wstrb_o      = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            ram_wstrb_o[b] = sel_we & strb_mask_bit(strb_ext, b);
        end
    end

    // Next-state for hold counter, ownership, pointer and read-return tag.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = 4'd0;
        last_owner_d = last_owner_q;
        rd_pend_d    = 1'b0;
        rd_idx_d     = rd_idx_q;
        if (win_vld) begin
            if (win_idx == last_owner_q) begin
                hold_cnt_d = (hold_cnt_q >= 4'(MAX_HOLD)) ? 4'(MAX_HOLD)
                                                          : hold_cnt_q + 4'd1;
            end else begin
                hold_cnt_d = 4'd1;
            end
            last_owner_d = win_idx;
            rr_ptr_d     = (win_idx == req_idx_t'(NUM_REQ - 1)) ? '0
                                                                : win_idx + req_idx_t'(1);
            if (!sel_we) begin
                rd_pend_d = 1'b1;
                rd_idx_d  = win_idx;
            end
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_q     <= '0;
            hold_cnt_q   <= 4'd0;
            last_owner_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_idx_q     <= rd_idx_d;
        end
    end

    // Read return: RAM output passes straight through, tagged to the reader.
    always_comb begin
        rdata_o  = ram_dout_i;
        rvalid_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rvalid_o[k] = rd_pend_q && (rd_idx_q == req_idx_t'(k));
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a bit-write RAM model behind it.
// A second instance with MAX_HOLD=1 exercises strict rotation.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_mem_req_arbiter;

    localparam int N  = 3;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk;
    logic rstn;

    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*SW-1:0] wstrb;

    logic [N-1:0]  gnt, rvalid;
    logic [DW-1:0] rdata;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wstrb, ram_din, ram_dout;

    logic [N-1:0]  gnt1, rvalid1;
    logic [DW-1:0] rdata1;
    logic          ram_cs1, ram_we1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wstrb1, ram_din1, ram_dout1;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;
    int cnt [N];

    logic [N-1:0] gexp [12];
    logic [N-1:0] prev;

    assign ram_dout1 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(4)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wstrb_i(wstrb), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wstrb_o(ram_wstrb), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    mem_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(1)) u_dut_h1 (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .wstrb_i(wstrb), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .ram_cs_o(ram_cs1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
        .ram_wstrb_o(ram_wstrb1), .ram_din_o(ram_din1), .ram_dout_i(ram_dout1)
    );

    // Bit-write RAM with registered read data; ld_* preloads words.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (ram_cs) begin
            if (ram_we) begin
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wstrb) | (ram_din & ram_wstrb);
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int k, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        req[k]              = r;
        we[k]               = w;
        addr[k*AW +: AW]    = a;
        wdata[k*DW +: DW]   = d;
        wstrb[k*SW +: SW]   = s;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        adv();
        rstn = 1'b1;
    endtask

    initial begin
        rstn  = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        ld_en = 1'b1;

        // Preload RAM while in reset.
        ld_addr = 14'h10; ld_data = 32'hDEADBEEF; adv();
        ld_addr = 14'h5;  ld_data = 32'h00000000; adv();
        ld_addr = 14'h7;  ld_data = 32'h12345678; adv();
        ld_en = 1'b0;

        @(negedge clk);
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_rvalid", rvalid, 3'b000);
        chk("rst_cs", ram_cs, 1'b0);
        chk("rst_cs_h1", ram_cs1, 1'b0);
        adv();
        rstn = 1'b1;

        // Single read by master 0.
        set_m(0, 1'b1, 1'b0, 14'h10, '0, '0);
        @(negedge clk);
        chk("rd_gnt", gnt, 3'b001);
        chk("rd_cs", ram_cs, 1'b1);
        chk("rd_we", ram_we, 1'b0);
        chk("rd_addr", ram_addr, 14'h10);
        chk("rd_wstrb", ram_wstrb, 32'h0);
        adv();
        req = '0;
        @(negedge clk);
        chk("rd_rvalid", rvalid, 3'b001);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("idle_gnt", gnt, 3'b000);
        chk("idle_cs", ram_cs, 1'b0);
        adv();

        // Strict rotation with MAX_HOLD=1, all three requesting.
        do_reset();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        req = 3'b111;
        we  = 3'b000;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("rot_gnt", gnt1, 3'b001 << (i % 3));
            for (int k = 0; k < N; k++) if (gnt1[k]) cnt[k]++;
            adv();
        end
        req = '0;
        chk("rot_cnt0", cnt[0], 10);
        chk("rot_cnt1", cnt[1], 10);
        chk("rot_cnt2", cnt[2], 10);

        // Hold limit: master 1 streams reads, master 2 joins at cycle 3.
        do_reset();
        gexp[0] = 3'b010; gexp[1] = 3'b010; gexp[2]  = 3'b010; gexp[3]  = 3'b010;
        gexp[4] = 3'b100; gexp[5] = 3'b010; gexp[6]  = 3'b010; gexp[7]  = 3'b010;
        gexp[8] = 3'b010; gexp[9] = 3'b010; gexp[10] = 3'b010; gexp[11] = 3'b000;
        prev = '0;
        for (int c = 0; c < 12; c++) begin
            set_m(1, (c <= 10), 1'b0, 14'(c), '0, '0);
            set_m(2, (c == 3 || c == 4), 1'b0, 14'h20, '0, '0);
            @(negedge clk);
            chk($sformatf("hold_gnt_c%0d", c), gnt, gexp[c]);
            chk($sformatf("hold_rvalid_c%0d", c), rvalid, prev);
            prev = gexp[c];
            adv();
        end
        req = '0;

        // Partial-strobe write then read back.
        set_m(0, 1'b1, 1'b1, 14'h5, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        chk("wr_gnt", gnt, 3'b001);
        chk("wr_we", ram_we, 1'b1);
        chk("wr_wstrb", ram_wstrb, 32'h0000FFFF);
        chk("wr_din", ram_din, 32'hFFFFFFFF);
        chk("wr_addr", ram_addr, 14'h5);
        adv();
        set_m(0, 1'b1, 1'b0, 14'h5, '0, '0);
        @(negedge clk);
        chk("wrrd_gnt", gnt, 3'b001);
        chk("wrrd_wstrb", ram_wstrb, 32'h0);
        chk("wr_no_rvalid", rvalid, 3'b000);
        adv();
        req = '0;
        @(negedge clk);
        chk("wrrd_rvalid", rvalid, 3'b001);
        chk("wrrd_rdata", rdata, 32'h0000FFFF);
        adv();

        // Zero-strobe write consumes the cycle but leaves the word intact.
        set_m(2, 1'b1, 1'b1, 14'h7, 32'hAAAAAAAA, 4'b0000);
        @(negedge clk);
        chk("wz_gnt", gnt, 3'b100);
        chk("wz_we", ram_we, 1'b1);
        chk("wz_wstrb", ram_wstrb, 32'h0);
        chk("wz_addr", ram_addr, 14'h7);
        adv();
        set_m(2, 1'b1, 1'b0, 14'h7, '0, '0);
        @(negedge clk);
        chk("wzrd_gnt", gnt, 3'b100);
        adv();
        req = '0;
        @(negedge clk);
        chk("wzrd_rvalid", rvalid, 3'b100);
        chk("wzrd_rdata", rdata, 32'h12345678);
        adv();

        // Reset while a read return is pending.
        set_m(0, 1'b1, 1'b0, 14'h10, '0, '0);
        @(negedge clk);
        chk("rr_gnt", gnt, 3'b001);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        req  = '0;
        #1;
        chk("rst_drop_async", rvalid, 3'b000);
        @(negedge clk);
        chk("rst_drop_neg", rvalid, 3'b000);
        chk("rst_drop_cs", ram_cs, 1'b0);
        adv();
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rel_rvalid", rvalid, 3'b000);
        adv();
        req = 3'b111;
        we  = 3'b000;
        @(negedge clk);
        chk("post_rst_gnt", gnt, 3'b001);
        chk("post_rst_gnt_h1", gnt1, 3'b001);
        chk("post_rst_rvalid", rvalid, 3'b000);
        adv();
        req = '0;
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
